// File: rtl/frame_rate_sequencer_pkg.sv
// frame_rate_sequencer_pkg: speed-mode encodings and default frame periods
package frame_rate_sequencer_pkg;
  typedef enum logic [1:0] {
    MODE_STOP = 2'b00,
    MODE_SLOW = 2'b01,
    MODE_MED  = 2'b10,
    MODE_FAST = 2'b11
  } mode_e;
  localparam int DEF_CNT_W       = 27;
  localparam int DEF_FRAME_W     = 5;
  localparam int DEF_NUM_FRAMES  = 20;
  localparam int DEF_PERIOD_SLOW = 50_000_000;
  localparam int DEF_PERIOD_MED  = 20_000_000;
  localparam int DEF_PERIOD_FAST = 2_000;
endpackage

// File: rtl/frame_rate_sequencer_tick_prescaler.sv
// tick_prescaler: free-running period counter; tick flags the terminal count
// so the owner can register its advance on the same edge the count wraps.
module tick_prescaler #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;
  logic             last;
  assign last = cnt == period - CNT_W'(1);
  assign tick = en & ~clr & last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else cnt <= (clr | ~en | last) ? '0 : cnt + CNT_W'(1);
  end
endmodule

// File: rtl/frame_rate_sequencer.sv
// frame_rate_sequencer: switch-selected frame rate, frame index sequencing
// with direction, single-step in stop mode and wrap indication.
module frame_rate_sequencer
  import frame_rate_sequencer_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int FRAME_W     = DEF_FRAME_W,
  parameter int NUM_FRAMES  = DEF_NUM_FRAMES,
  parameter int PERIOD_SLOW = DEF_PERIOD_SLOW,
  parameter int PERIOD_MED  = DEF_PERIOD_MED,
  parameter int PERIOD_FAST = DEF_PERIOD_FAST
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         sw_state,
  input  logic               dir,
  input  logic               step,
  output logic               fc_tick,
  output logic [FRAME_W-1:0] fm_no,
  output logic               wrap,
  output logic               running
);
  localparam logic [FRAME_W-1:0] LAST = FRAME_W'(NUM_FRAMES - 1);
  mode_e              mode_q;
  logic [CNT_W-1:0]   period;
  logic               tick, adv, wrap_n;
  logic [FRAME_W-1:0] next;
  always_comb begin
    period = mode_q == MODE_SLOW ? CNT_W'(PERIOD_SLOW) :
             mode_q == MODE_MED  ? CNT_W'(PERIOD_MED)  : CNT_W'(PERIOD_FAST);
    wrap_n = dir ? fm_no == '0 : fm_no == LAST;
    next   = wrap_n ? (dir ? LAST : '0) :
             (dir ? fm_no - FRAME_W'(1) : fm_no + FRAME_W'(1));
    adv    = tick | (mode_q == MODE_STOP & step);
  end
  // a pending mode change restarts the new period from zero
  tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (mode_q != MODE_STOP),
    .clr    (sw_state != mode_q),
    .period (period),
    .tick   (tick)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_STOP;
      running <= 1'b0;
      fc_tick <= 1'b0;
      wrap    <= 1'b0;
      fm_no   <= '0;
    end else begin
      mode_q  <= mode_e'(sw_state);
      running <= sw_state != MODE_STOP;
      fc_tick <= adv;
      wrap    <= adv & wrap_n;
      if (adv) fm_no <= next;
    end
  end
endmodule

// File: tb/tb_frame_rate_sequencer.sv
// tb_frame_rate_sequencer: directed scenarios plus random stimulus, checked
// every cycle against an age-since-mode-change reference model.
module tb_frame_rate_sequencer;
  localparam int N = 4, PS = 8, PM = 4, PF = 1;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [1:0] sw_state = 2'b00;
  logic       dir = 1'b0, step = 1'b0;
  logic       fc_tick, wrap, running;
  logic [4:0] fm_no;
  int checks = 0, errors = 0;
  int m_mode, m_age, m_frame;
  bit m_tick, m_wrap;
  always #5 clk = ~clk;
  frame_rate_sequencer #(
    .CNT_W(27), .FRAME_W(5), .NUM_FRAMES(N),
    .PERIOD_SLOW(PS), .PERIOD_MED(PM), .PERIOD_FAST(PF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_state(sw_state), .dir(dir), .step(step),
    .fc_tick(fc_tick), .fm_no(fm_no), .wrap(wrap), .running(running)
  );
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  function automatic int per(input int m);
    return m == 1 ? PS : m == 2 ? PM : PF;
  endfunction
  task automatic model_reset();
    m_mode = 0; m_age = 0; m_frame = 0; m_tick = 0; m_wrap = 0;
  endtask
  // age = edges since the registered mode took its value; ticks land on multiples of P
  task automatic model_edge();
    bit adv;
    adv = 0;
    if (!rst_n) begin model_reset(); return; end
    if (m_mode == 0) adv = step;
    else if (int'(sw_state) == m_mode) begin
      m_age++;
      adv = (m_age % per(m_mode)) == 0;
    end
    if (int'(sw_state) != m_mode) begin m_mode = sw_state; m_age = 0; end
    m_tick = adv;
    m_wrap = adv && (dir ? m_frame == 0 : m_frame == N - 1);
    if (adv) m_frame = (m_frame + (dir ? N - 1 : 1)) % N;
  endtask
  task automatic compare();
    check_eq("fc_tick", fc_tick, m_tick);
    check_eq("wrap", wrap, m_wrap);
    check_eq("fm_no", fm_no, m_frame);
    check_eq("running", running, m_mode != 0);
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1 compare();
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare();
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    #1 compare();
    @(negedge clk) rst_n = 1'b1;
    repeat (20) cyc();
    sw_state = 2'b10; dir = 1'b0;
    cyc();
    check_eq("running_lag", running, 1);
    repeat (17) cyc();
    sw_state = 2'b01;
    repeat (6) cyc();
    sw_state = 2'b11;
    cyc();
    check_eq("no_tick_on_switch", fc_tick, 0);
    repeat (6) cyc();
    sw_state = 2'b00;
    cyc();
    for (int i = 0; i < N && m_frame != 0; i++) begin step = 1'b1; cyc(); step = 1'b0; cyc(); end
    check_eq("at_frame0", fm_no, 0);
    dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; cyc();
      check_eq("step_frame", fm_no, 3 - i);
      check_eq("step_wrap", wrap, i == 0);
      step = 1'b0; cyc();
    end
    sw_state = 2'b10; repeat (2) cyc();
    step = 1'b1; cyc(); step = 1'b0; repeat (3) cyc();
    sw_state = 2'b01; dir = 1'b0;
    repeat (7) cyc();
    async_reset();
    check_eq("reset_fm_no", fm_no, 0);
    repeat (12) cyc();
    sw_state = 2'b10;
    repeat (3) cyc();
    for (int i = 0; i < 8 && !fc_tick; i++) cyc();
    check_eq("tick_seen", fc_tick, 1);
    repeat (2) cyc();
    dir = ~dir;
    repeat (6) cyc();
    repeat (400) begin
      if ($urandom_range(0, 19) == 0) sw_state = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      step = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 149) == 0) async_reset();
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
